mult_issue_queue: RTL and testbench



---
 rtl/mult_issue_queue.sv | 108 ++++++++++
 tb/tb_mult_issue_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_queue.sv
// In-order issue queue feeding the multiplier: buffers dispatched operations,
// snoops the CDB for missing source operands and issues the head when ready.
package mult_issue_queue_pkg;
    typedef struct packed {
        logic [31:0] rs1_data;
        logic [5:0]  rs1_tag;
        logic        rs1_data_valid;
        logic [31:0] rs2_data;
        logic [5:0]  rs2_tag;
        logic        rs2_data_valid;
        logic [5:0]  rd_tag;
        logic        wb_valid;
    } common_fifo_data;
endpackage

module mult_issue_queue
    import mult_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dispatch_en,
    input  common_fifo_data i_fifo_data,
    input  logic            cdb_valid,
    input  logic [5:0]      cdb_tag,
    input  logic [31:0]     cdb_data,
    input  logic            flush,
    input  logic            issue_ready,
    output logic            issue_valid,
    output common_fifo_data o_issue_data,
    output logic            full,
    output logic            empty
);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    common_fifo_data        entries [DEPTH];
    logic [DEPTH-1:0]       entry_valid;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;
    logic                   do_enq;
    logic                   do_deq;
    common_fifo_data        enq_entry;
    common_fifo_data        head;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = entries[rd_ptr];

    // Handshake: a transfer happens on a posedge where issue_valid && issue_ready;
    // issue_valid depends only on registered state, never on issue_ready.
    assign issue_valid  = !empty && head.rs1_data_valid && head.rs2_data_valid;
    assign o_issue_data = empty ? '0 : head;

    // full is taken before dequeue, so a full queue never accepts even while draining.
    assign do_enq = dispatch_en && !full;
    assign do_deq = issue_valid && issue_ready;

    always_comb begin
        enq_entry = i_fifo_data;
        if (cdb_valid && !i_fifo_data.rs1_data_valid && i_fifo_data.rs1_tag == cdb_tag) begin
            enq_entry.rs1_data       = cdb_data;
            enq_entry.rs1_data_valid = 1'b1;
        end
        if (cdb_valid && !i_fifo_data.rs2_data_valid && i_fifo_data.rs2_tag == cdb_tag) begin
            enq_entry.rs2_data       = cdb_data;
            enq_entry.rs2_data_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_valid[i] && cdb_valid) begin
                    if (!entries[i].rs1_data_valid && entries[i].rs1_tag == cdb_tag) begin
                        entries[i].rs1_data       <= cdb_data;
                        entries[i].rs1_data_valid <= 1'b1;
                    end
                    if (!entries[i].rs2_data_valid && entries[i].rs2_tag == cdb_tag) begin
                        entries[i].rs2_data       <= cdb_data;
                        entries[i].rs2_data_valid <= 1'b1;
                    end
                end
            end
            // The write slot is never occupied when do_enq is set, so it cannot collide with wakeup.
            if (do_enq) begin
                entries[wr_ptr]     <= enq_entry;
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + 1'b1;
            end
            if (do_enq && !do_deq)
                count <= count + 1'b1;
            else if (!do_enq && do_deq)
                count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_mult_issue_queue.sv
// Self-checking bench for mult_issue_queue: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_mult_issue_queue;
    import mult_issue_queue_pkg::*;

    localparam int DEPTH = 4;

    logic            clk;
    logic            rst;
    logic            dispatch_en;
    common_fifo_data i_fifo_data;
    logic            cdb_valid;
    logic [5:0]      cdb_tag;
    logic [31:0]     cdb_data;
    logic            flush;
    logic            issue_ready;
    logic            issue_valid;
    common_fifo_data o_issue_data;
    logic            full;
    logic            empty;

    int checks = 0;
    int errors = 0;
    common_fifo_data mq[$];

    mult_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .dispatch_en(dispatch_en), .i_fifo_data(i_fifo_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
        .issue_ready(issue_ready), .issue_valid(issue_valid), .o_issue_data(o_issue_data),
        .full(full), .empty(empty)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic common_fifo_data snoop(common_fifo_data e, logic cv, logic [5:0] ct,
                                              logic [31:0] cd);
        common_fifo_data r = e;
        if (cv && !r.rs1_data_valid && r.rs1_tag == ct) begin
            r.rs1_data = cd; r.rs1_data_valid = 1'b1;
        end
        if (cv && !r.rs2_data_valid && r.rs2_tag == ct) begin
            r.rs2_data = cd; r.rs2_data_valid = 1'b1;
        end
        return r;
    endfunction

    function automatic common_fifo_data mk(logic [31:0] d1, logic [5:0] t1, logic v1,
                                           logic [31:0] d2, logic [5:0] t2, logic v2,
                                           logic [5:0] rd);
        common_fifo_data e;
        e.rs1_data = d1; e.rs1_tag = t1; e.rs1_data_valid = v1;
        e.rs2_data = d2; e.rs2_tag = t2; e.rs2_data_valid = v2;
        e.rd_tag = rd; e.wb_valid = 1'b1;
        return e;
    endfunction

    // Reference model: one clock edge applied to the list of queued operations.
    task automatic model_step();
        bit head_ready;
        bit was_full;
        if (rst || flush) begin
            mq.delete();
            return;
        end
        was_full   = (mq.size() == DEPTH);
        head_ready = (mq.size() > 0) && mq[0].rs1_data_valid && mq[0].rs2_data_valid;
        if (head_ready && issue_ready) void'(mq.pop_front());
        foreach (mq[i]) mq[i] = snoop(mq[i], cdb_valid, cdb_tag, cdb_data);
        if (dispatch_en && !was_full) mq.push_back(snoop(i_fifo_data, cdb_valid, cdb_tag, cdb_data));
    endtask

    task automatic check_outputs();
        common_fifo_data exp_d;
        bit exp_v;
        exp_d = (mq.size() > 0) ? mq[0] : '0;
        exp_v = (mq.size() > 0) && mq[0].rs1_data_valid && mq[0].rs2_data_valid;
        check("issue_valid", issue_valid, exp_v);
        check("issue_data", o_issue_data, exp_d);
        check("full", full, mq.size() == DEPTH);
        check("empty", empty, mq.size() == 0);
    endtask

    // driver: inputs change at negedge, outputs checked there, model advances at posedge
    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst = 1'b0; flush = 1'b0; dispatch_en = 1'b0; i_fifo_data = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = 1'b0;
        check("rst_issue_valid", issue_valid, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_data", o_issue_data, 128'd0);
        tick();

        // single ready entry issues one cycle after enqueue
        i_fifo_data = mk(32'd5, 6'h0, 1'b1, 32'd7, 6'h0, 1'b1, 6'h03);
        dispatch_en = 1'b1; issue_ready = 1'b1;
        tick();
        dispatch_en = 1'b0;
        check("t2_valid", issue_valid, 1'b1);
        check("t2_rs1", o_issue_data.rs1_data, 32'd5);
        check("t2_rs2", o_issue_data.rs2_data, 32'd7);
        check("t2_rd", o_issue_data.rd_tag, 6'h03);
        tick();
        check("t2_empty", empty, 1'b1);

        // CDB wakeup of a waiting rs2
        i_fifo_data = mk(32'd1, 6'h0, 1'b1, 32'd0, 6'h12, 1'b0, 6'h04);
        dispatch_en = 1'b1;
        tick();
        dispatch_en = 1'b0;
        check("t3_wait", issue_valid, 1'b0);
        tick();
        cdb_valid = 1'b1; cdb_tag = 6'h12; cdb_data = 32'hDEADBEEF; issue_ready = 1'b0;
        tick();
        cdb_valid = 1'b0;
        check("t3_woken", issue_valid, 1'b1);
        check("t3_rs2", o_issue_data.rs2_data, 32'hDEADBEEF);
        issue_ready = 1'b1;
        tick();

        // capture from CDB during enqueue
        i_fifo_data = mk(32'd0, 6'h05, 1'b0, 32'd9, 6'h0, 1'b1, 6'h06);
        dispatch_en = 1'b1; cdb_valid = 1'b1; cdb_tag = 6'h05; cdb_data = 32'h10;
        tick();
        dispatch_en = 1'b0; cdb_valid = 1'b0;
        check("t4_valid", issue_valid, 1'b1);
        check("t4_rs1", o_issue_data.rs1_data, 32'h10);
        check("t4_rs1v", o_issue_data.rs1_data_valid, 1'b1);
        tick();

        // fill past capacity, then drain in order across the pointer wrap
        issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_fifo_data = mk(32'd100 + k, 6'h0, 1'b1, 32'd200 + k, 6'h0, 1'b1, 6'(k));
            dispatch_en = 1'b1;
            tick();
            if (k == 3) check("t5_full", full, 1'b1);
        end
        dispatch_en = 1'b0; issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t5_order", o_issue_data.rs1_data, 32'd100 + k);
            tick();
        end
        check("t5_empty", empty, 1'b1);

        // flush, then reset, with three entries queued and a dispatch in flight
        for (int pass = 0; pass < 2; pass++) begin
            issue_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                i_fifo_data = mk(32'd300 + k, 6'h0, 1'b1, 32'd1, 6'h0, 1'b1, 6'h1);
                dispatch_en = 1'b1;
                tick();
            end
            if (pass == 0) flush = 1'b1; else rst = 1'b1;
            issue_ready = 1'b1;
            tick();
            set_idle();
            check("t6_empty", empty, 1'b1);
            check("t6_valid", issue_valid, 1'b0);
            check("t6_full", full, 1'b0);
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            dispatch_en = ($urandom_range(0, 99) < 60);
            i_fifo_data = mk($urandom, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             $urandom, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             6'($urandom_range(0, 63)));
            cdb_valid   = ($urandom_range(0, 99) < 50);
            cdb_tag     = 6'($urandom_range(0, 7));
            cdb_data    = $urandom;
            issue_ready = ($urandom_range(0, 99) < 55);
            flush       = ($urandom_range(0, 199) == 0);
            rst         = ($urandom_range(0, 399) == 0);
            tick();
        end
        set_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
